nested_pipe_chain: RTL and testbench



---
 rtl/nested_pipe_chain.sv | 84 ++++++++
 tb/tb_nested_pipe_chain.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_pipe_chain.sv
// nested_pipe_chain: STAGES cascaded valid/ready register slices
// with synchronous flush and an occupancy count.
module nested_pipe_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 3,
  parameter int CNT_W  = (STAGES < 1) ? 1 : $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (STAGES == 0) begin : g_wire
    assign in_ready  = out_ready & ~flush;
    assign out_valid = in_valid & ~flush;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    localparam int L = STAGES - 1;

    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [STAGES-1:0] r;
    logic [CNT_W-1:0]  cnt;

    // Ready ripples back from the output; a bubble anywhere
    // downstream lets every slice before it advance.
    always_comb begin
      logic acc;
      acc = out_ready;
      for (int i = L; i >= 0; i--) begin
        acc  = ~v_q[i] | acc;
        r[i] = acc;
      end
    end

    always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (r[0]) begin
        v_d[0] = in_valid & ~flush;
        d_d[0] = in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (r[i]) begin
          v_d[i] = v_q[i-1];
          d_d[i] = d_q[i-1];
        end
      end
      if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

    always_comb begin
      cnt = '0;
      for (int i = 0; i < STAGES; i++) begin
        cnt = cnt + CNT_W'(v_q[i]);
      end
    end

    assign occupancy = cnt;
    assign in_ready  = r[0] & ~flush;
    assign out_valid = v_q[L];
    assign out_data  = v_q[L] ? d_q[L] : '0;
  end

endmodule

// File: tb/tb_nested_pipe_chain.sv
// Directed bench for nested_pipe_chain: STAGES=3, 0 and 1.
module tb_nested_pipe_chain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // main DUT: WIDTH=4, STAGES=3
  logic       flush = 0, in_valid = 0, out_ready = 1;
  logic [3:0] in_data = '0;
  logic       in_ready, out_valid;
  logic [3:0] out_data;
  logic [1:0] occ;

  nested_pipe_chain #(.WIDTH(4), .STAGES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occ)
  );

  // STAGES=0, WIDTH=8
  logic       z_flush = 0, z_iv = 0, z_or = 0;
  logic [7:0] z_id = '0;
  logic       z_ir, z_ov;
  logic [7:0] z_od;
  logic [0:0] z_occ;

  nested_pipe_chain #(.WIDTH(8), .STAGES(0)) u_z (
    .clk(clk), .rst_n(rst_n), .flush(z_flush),
    .in_valid(z_iv), .in_ready(z_ir), .in_data(z_id),
    .out_valid(z_ov), .out_ready(z_or),
    .out_data(z_od), .occupancy(z_occ)
  );

  // STAGES=1, WIDTH=4
  logic       o_flush = 0, o_iv = 0, o_or = 1;
  logic [3:0] o_id = '0;
  logic       o_ir, o_ov;
  logic [3:0] o_od;
  logic [0:0] o_occ;

  nested_pipe_chain #(.WIDTH(4), .STAGES(1)) u_one (
    .clk(clk), .rst_n(rst_n), .flush(o_flush),
    .in_valid(o_iv), .in_ready(o_ir), .in_data(o_id),
    .out_valid(o_ov), .out_ready(o_or),
    .out_data(o_od), .occupancy(o_occ)
  );

  // Stall stability monitor on the main DUT
  logic       hold = 0, rst_seen = 0;
  logic [3:0] hold_d = '0;
  always @(negedge rst_n) rst_seen = 1'b1;
  always @(negedge clk) begin
    if (hold && rst_n && !rst_seen) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== hold_d) begin
        fails++;
        $display("FAIL stall_stable: valid=%b data=%h want 1/%h",
                 out_valid, out_data, hold_d);
      end
    end
    hold     = out_valid && !out_ready && !flush && rst_n;
    hold_d   = out_data;
    rst_seen = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({out_valid, out_data, occ, in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_out: v=%b d=%h occ=%0d rdy=%b want 0/0/0/1",
               out_valid, out_data, occ, in_ready);
    end
    flush = 1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_flush_rdy: got %b want 0", in_ready);
    end
    flush = 0;
    #3;
    rst_n = 1;
    tick();
  endtask

  task automatic test_latency();
    out_ready = 1;
    in_valid = 1; in_data = 4'h1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || occ !== 2'd1) begin
      fails++;
      $display("FAIL lat_c1: v=%b occ=%0d want 0/1", out_valid, occ);
    end
    in_data = 4'h2;
    tick();
    tests++;
    if (out_valid !== 1'b0 || occ !== 2'd2) begin
      fails++;
      $display("FAIL lat_c2: v=%b occ=%0d want 0/2", out_valid, occ);
    end
    in_data = 4'h3;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'h1 || occ !== 2'd3) begin
      fails++;
      $display("FAIL lat_c3: v=%b d=%h occ=%0d want 1/1/3",
               out_valid, out_data, occ);
    end
    in_data = 4'h4;
    tick();
    in_valid = 0;
    for (int k = 2; k <= 4; k++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'(k)) begin
        fails++;
        $display("FAIL lat_seq: v=%b d=%h want 1/%h",
                 out_valid, out_data, 4'(k));
      end
      tick();
    end
    tests++;
    if ({out_valid, out_data, occ} !== {1'b0, 4'h0, 2'd0}) begin
      fails++;
      $display("FAIL lat_drain: v=%b d=%h occ=%0d want 0/0/0",
               out_valid, out_data, occ);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp [4];
    exp[0] = 4'hB; exp[1] = 4'hC; exp[2] = 4'hD; exp[3] = 4'h0;
    out_ready = 0;
    in_valid = 1; in_data = 4'hA;
    tick();
    in_data = 4'hB;
    tick();
    in_data = 4'hC;
    tick();
    in_valid = 0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || occ !== 2'd3 || out_data !== 4'hA) begin
      fails++;
      $display("FAIL bp_full: rdy=%b occ=%0d d=%h want 0/3/a",
               in_ready, occ, out_data);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || occ !== 2'd3) begin
      fails++;
      $display("FAIL bp_hold: v=%b d=%h occ=%0d want 1/a/3",
               out_valid, out_data, occ);
    end
    // release and push D in the same cycle
    out_ready = 1; in_valid = 1; in_data = 4'hD;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_data !== 4'hA) begin
      fails++;
      $display("FAIL bp_release: rdy=%b d=%h want 1/a", in_ready, out_data);
    end
    tick();
    in_valid = 0;
    tests++;
    if (occ !== 2'd3) begin
      fails++;
      $display("FAIL pass_occ: occ=%0d want 3", occ);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (out_valid !== (k < 3) || out_data !== exp[k]) begin
        fails++;
        $display("FAIL bp_order: v=%b d=%h want %b/%h",
                 out_valid, out_data, k < 3, exp[k]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_data = 4'h5;
    tick();
    in_data = 4'h6;
    tick();
    flush = 1; in_data = 4'h7;
    #1;
    tests++;
    if (in_ready !== 1'b0 || occ !== 2'd2) begin
      fails++;
      $display("FAIL flush_cyc: rdy=%b occ=%0d want 0/2", in_ready, occ);
    end
    tick();
    flush = 0; in_valid = 0;
    tests++;
    if ({out_valid, out_data, occ} !== {1'b0, 4'h0, 2'd0}) begin
      fails++;
      $display("FAIL flush_after: v=%b d=%h occ=%0d want 0/0/0",
               out_valid, out_data, occ);
    end
    out_ready = 1;
    repeat (3) tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_lost: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    in_valid = 1; in_data = 4'h8;
    tick();
    in_data = 4'h9;
    tick();
    in_valid = 0;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'h8 || occ !== 2'd2) begin
      fails++;
      $display("FAIL rmid_pre: v=%b d=%h occ=%0d want 1/8/2",
               out_valid, out_data, occ);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({out_valid, out_data, occ} !== {1'b0, 4'h0, 2'd0}) begin
      fails++;
      $display("FAIL rmid_async: v=%b d=%h occ=%0d want 0/0/0",
               out_valid, out_data, occ);
    end
    #2;
    rst_n = 1;
    out_ready = 1;
    tick();
    in_valid = 1; in_data = 4'hE;
    tick();
    in_valid = 0;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_early: v=%b want 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'hE) begin
      fails++;
      $display("FAIL rmid_lat: v=%b d=%h want 1/e", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_stages0();
    z_iv = 1; z_id = 8'hC3; z_or = 1;
    #1;
    tests++;
    if ({z_ov, z_od, z_ir, z_occ} !== {1'b1, 8'hC3, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL s0_pass: v=%b d=%h rdy=%b occ=%0d want 1/c3/1/0",
               z_ov, z_od, z_ir, z_occ);
    end
    z_or = 0;
    #1;
    tests++;
    if (z_ir !== 1'b0) begin
      fails++;
      $display("FAIL s0_rdy: got %b want 0", z_ir);
    end
    z_or = 1; z_flush = 1;
    #1;
    tests++;
    if (z_ov !== 1'b0 || z_ir !== 1'b0) begin
      fails++;
      $display("FAIL s0_flush: v=%b rdy=%b want 0/0", z_ov, z_ir);
    end
    z_flush = 0; z_iv = 0;
  endtask

  task automatic test_back_to_back();
    o_or = 1;
    o_iv = 1; o_id = 4'h1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      o_id = 4'(k + 1);
      #1;
      tests++;
      if (o_ov !== 1'b1 || o_od !== 4'(k) || o_ir !== 1'b1 || o_occ !== 1'b1) begin
        fails++;
        $display("FAIL s1_b2b: v=%b d=%h rdy=%b occ=%0d want 1/%h/1/1",
                 o_ov, o_od, o_ir, o_occ, 4'(k));
      end
      tick();
    end
    o_iv = 0;
    tick();
    tests++;
    if (o_ov !== 1'b0 || o_od !== 4'h0 || o_occ !== 1'b0) begin
      fails++;
      $display("FAIL s1_drain: v=%b d=%h occ=%0d want 0/0/0",
               o_ov, o_od, o_occ);
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_latency();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_stages0();
        test_back_to_back();
      end
      begin
        #20000;
        fails++;
        $display("FAIL timeout: bench exceeded time budget");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
